// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter in front of a fixed-latency RAM port
// One transaction in flight: IDLE captures a winner, BUSY drives the RAM, RESP returns the result.
module mem_arbiter #(
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_data,
  input  logic        i_req_wen,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_data,
  input  logic        d_req_wen,
  output logic        i_resp_valid,
  output logic [31:0] i_resp_data,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_wen,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic        last_d;
  logic        gnt_d;
  logic        grant_d;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic        lat_wen;
  logic [3:0]  cnt;

  // D wins a tie only when I was granted most recently
  assign grant_d = d_req_valid && (!i_req_valid || !last_d);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req_valid || d_req_valid) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    mem_addr     = 32'd0;
    mem_data     = 32'd0;
    mem_wen      = 1'b0;
    i_resp_valid = 1'b0;
    d_resp_valid = 1'b0;
    if (state == BUSY) begin
      mem_addr = lat_addr;
      mem_data = lat_data;
      mem_wen  = lat_wen;
    end
    if (state == RESP) begin
      i_resp_valid = !gnt_d;
      d_resp_valid = gnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d      <= 1'b0;
      gnt_d       <= 1'b0;
      lat_addr    <= 32'd0;
      lat_data    <= 32'd0;
      lat_wen     <= 1'b0;
      cnt         <= 4'd0;
      i_resp_data <= 32'd0;
      d_resp_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid || d_req_valid) begin
            gnt_d    <= grant_d;
            last_d   <= grant_d;
            lat_addr <= grant_d ? d_req_addr : i_req_addr;
            lat_data <= grant_d ? d_req_data : i_req_data;
            lat_wen  <= grant_d ? d_req_wen  : i_req_wen;
            cnt      <= LAT_M1;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (gnt_d) begin
            d_resp_data <= lat_wen ? 32'd0 : mem_rdata;
          end else begin
            i_resp_data <= lat_wen ? 32'd0 : mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4, meaning cycles from request capture to valid mem_rdata; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock (CPU clock); all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports i_req_valid input 1, i_req_addr input 32, i_req_data input 32, i_req_wen input 1: instruction-side request.
REQ-005 SHALL have ports d_req_valid input 1, d_req_addr input 32, d_req_data input 32, d_req_wen input 1: data-side request.
REQ-006 SHALL have ports i_resp_valid output 1, i_resp_data output 32, d_resp_valid output 1, d_resp_data output 32: per-requester response.
REQ-007 SHALL have ports mem_addr output 32, mem_data output 32, mem_wen output 1, mem_rdata input 32: the shared RAM port.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-010 SHALL, in IDLE, start a transaction when i_req_valid or d_req_valid is high, latching the winner's addr, data and wen, and move to BUSY next cycle.
REQ-011 SHALL arbitrate round-robin: on simultaneous valids, grant the requester not granted most recently; a single valid is always granted.
REQ-012 SHALL update last_grant only when a grant is issued.
REQ-013 SHALL, in BUSY, drive mem_addr, mem_data and mem_wen from the latched values and load a 4-bit counter with MEM_LATENCY-1 on entry, decrementing each cycle.
REQ-014 SHALL leave BUSY for RESP in the cycle after the counter reads 0, so BUSY lasts exactly MEM_LATENCY cycles.
REQ-015 SHALL, in RESP, pulse the granted requester's resp_valid for exactly one cycle and return to IDLE.
REQ-016 SHALL drive resp_data with mem_rdata captured on the last BUSY cycle for reads, and with 0 for writes.
REQ-017 SHALL make total latency MEM_LATENCY+1 cycles: a request captured in cycle 0 gets resp_valid in cycle MEM_LATENCY+1.
REQ-018 SHALL drive mem_addr, mem_data and mem_wen to 0 outside BUSY.
REQ-019 SHALL hold the non-granted requester's resp_valid at 0 and leave its pending request waiting; the requester holds valid and its payload stable.
REQ-020 SHALL complete a transaction even if the granted requester drops valid during BUSY, including its RESP pulse.
REQ-021 SHALL ignore all request inputs in BUSY and RESP; a valid still high in the IDLE cycle after RESP is a new request.
REQ-022 SHALL hold each resp_data at its last value when the matching resp_valid is 0.

Reset
REQ-023 SHALL, with rst high at a clock edge, go to IDLE, set last_grant to I (so D wins the first tie), clear the counter, and zero all outputs, including resp data.
REQ-024 SHALL abort an in-flight transaction on reset: no resp_valid, and mem_wen is 0 from the cycle after the reset edge.

Verification
REQ-025 SHALL check: d read, addr 0x10, mem_rdata 0xDEADBEEF, L=4 -> mem_addr 0x10 for 4 cycles, d_resp_valid in cycle 5, d_resp_data 0xDEADBEEF.
REQ-026 SHALL check: i and d valid together after reset -> D granted first; I granted in the IDLE cycle after D's RESP, with i_resp_valid 5 cycles later.
REQ-027 SHALL check: i write, addr 0x20, data 0x12345678 -> mem_wen high for exactly 4 cycles with that addr and data; i_resp_valid pulses with data 0.
REQ-028 SHALL check: d_req_valid dropped in the 2nd BUSY cycle -> transaction still completes, with d_resp_valid in cycle 5.
REQ-029 SHALL check: rst asserted in the 3rd BUSY cycle of a write -> mem_wen 0 next cycle, no resp_valid, busy 0, and the next tie is granted to D.
REQ-030 SHALL check: with MEM_LATENCY=1, alternating continuous i/d reads -> grants strictly alternate, one response every 3 cycles.
